// File: rtl/truth_table_sweeper.sv
// Exhaustive stimulus engine: walks every input vector of a small combinational
// block, samples its response after HOLD cycles and scores it against EXPECTED.
module truth_table_sweeper #(
  parameter int unsigned               N_IN     = 4,
  parameter int unsigned               HOLD     = 20,
  parameter logic [(2**N_IN)-1:0]      EXPECTED = 16'h4644,
  parameter int unsigned               ERR_W    = N_IN + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              dut_in,
  output logic [N_IN-1:0]   vec_out,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ERR_W-1:0]  err_count,
  output logic              first_err_valid,
  output logic [N_IN-1:0]   first_err_idx
);

  localparam int unsigned HOLD_W = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD - 1);
  localparam logic [N_IN-1:0]   VEC_LAST  = {N_IN{1'b1}};
  localparam logic [ERR_W-1:0]  ERR_MAX   = {ERR_W{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [N_IN-1:0]    vec_q, vec_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               pass_q, pass_d;
  logic [ERR_W-1:0]   err_q, err_d;
  logic               fev_q, fev_d;
  logic [N_IN-1:0]    fei_q, fei_d;

  logic               mismatch_c;
  logic [ERR_W-1:0]   err_upd_c;

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      vec_q   <= '0;
      hold_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      fev_q   <= 1'b0;
      fei_q   <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      hold_q  <= hold_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      fev_q   <= fev_d;
      fei_q   <= fei_d;
    end
  end

  // Next-state: sweep sequencing and scoring
  always_comb begin
    state_d    = state_q;
    vec_d      = vec_q;
    hold_d     = hold_q;
    busy_d     = busy_q;
    done_d     = done_q;
    pass_d     = pass_q;
    err_d      = err_q;
    fev_d      = fev_q;
    fei_d      = fei_q;
    mismatch_c = (dut_in != EXPECTED[vec_q]);
    err_upd_c  = (mismatch_c && (err_q != ERR_MAX)) ? (err_q + ERR_W'(1)) : err_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_DRIVE;
          vec_d   = '0;
          hold_d  = '0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          err_d   = '0;
          fev_d   = 1'b0;
          fei_d   = '0;
        end
      end
      S_DRIVE: begin
        if (hold_q == HOLD_LAST) begin
          err_d  = err_upd_c;
          hold_d = '0;
          if (mismatch_c && !fev_q) begin
            fev_d = 1'b1;
            fei_d = vec_q;
          end
          // Pass is judged on the count including the final vector's result
          if (vec_q == VEC_LAST) begin
            state_d = S_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (err_upd_c == '0);
          end else begin
            vec_d = vec_q + N_IN'(1);
          end
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign vec_out         = vec_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign pass            = pass_q;
  assign err_count       = err_q;
  assign first_err_valid = fev_q;
  assign first_err_idx   = fei_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: two instances (HOLD=20 and HOLD=1/ERR_W=2)
// scored every cycle against a timeline model derived from elapsed cycles.
module tb_truth_table_sweeper;

  logic clk;
  logic rst_n;
  logic start_a, start_b;
  logic dut_in_a, dut_in_b;
  logic [15:0] mask_a, mask_b;

  logic [3:0] vec_a, vec_b, fei_a, fei_b;
  logic       busy_a, busy_b, done_a, done_b, pass_a, pass_b, fev_a, fev_b;
  logic [4:0] err_a;
  logic [1:0] err_b;

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 0;

  // model state per instance, indexed 0 = a, 1 = b
  int m_t[2], m_busy[2], m_done[2], m_pass[2], m_err[2], m_fev[2], m_fei[2], m_vec[2];

  truth_table_sweeper #(.N_IN(4), .HOLD(20), .EXPECTED(16'h4644), .ERR_W(5)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .dut_in(dut_in_a),
    .vec_out(vec_a), .busy(busy_a), .done(done_a), .pass(pass_a),
    .err_count(err_a), .first_err_valid(fev_a), .first_err_idx(fei_a));

  truth_table_sweeper #(.N_IN(4), .HOLD(1), .EXPECTED(16'h4644), .ERR_W(2)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .dut_in(dut_in_b),
    .vec_out(vec_b), .busy(busy_b), .done(done_b), .pass(pass_b),
    .err_count(err_b), .first_err_valid(fev_b), .first_err_idx(fei_b));

  // t = r.s' + p.q'.r'.s with {p,q,r,s} = vector; mask flips chosen vectors
  function automatic logic dev_val(input logic [3:0] v, input logic [15:0] m);
    logic p, q, r, s;
    {p, q, r, s} = v;
    return ((r & ~s) | (p & ~q & ~r & s)) ^ m[v];
  endfunction

  assign dut_in_a = dev_val(vec_a, mask_a);
  assign dut_in_b = dev_val(vec_b, mask_b);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int out_val(input int inst, input int idx);
    case (idx)
      0: return (inst == 0) ? int'(vec_a)  : int'(vec_b);
      1: return (inst == 0) ? int'(busy_a) : int'(busy_b);
      2: return (inst == 0) ? int'(done_a) : int'(done_b);
      3: return (inst == 0) ? int'(pass_a) : int'(pass_b);
      4: return (inst == 0) ? int'(err_a)  : int'(err_b);
      5: return (inst == 0) ? int'(fev_a)  : int'(fev_b);
      default: return (inst == 0) ? int'(fei_a) : int'(fei_b);
    endcase
  endfunction

  function automatic int model_val(input int inst, input int idx);
    case (idx)
      0: return m_vec[inst];
      1: return m_busy[inst];
      2: return m_done[inst];
      3: return m_pass[inst];
      4: return m_err[inst];
      5: return m_fev[inst];
      default: return m_fei[inst];
    endcase
  endfunction

  function automatic string out_name(input int inst, input int idx);
    string n;
    case (idx)
      0: n = "vec_out";
      1: n = "busy";
      2: n = "done";
      3: n = "pass";
      4: n = "err_count";
      5: n = "first_err_valid";
      default: n = "first_err_idx";
    endcase
    return $sformatf("%s.%s", (inst == 0) ? "a" : "b", n);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_t[i] = 0; m_busy[i] = 0; m_done[i] = 0; m_pass[i] = 0;
      m_err[i] = 0; m_fev[i] = 0; m_fei[i] = 0; m_vec[i] = 0;
    end
  endtask

  // Timeline model: vector k is held over cycles [k*HOLD, (k+1)*HOLD) after start
  task automatic model_step(input int i);
    int hold, emax, k;
    logic st;
    logic [15:0] mk;
    hold = (i == 0) ? 20 : 1;
    emax = (i == 0) ? 31 : 3;
    st   = (i == 0) ? start_a : start_b;
    mk   = (i == 0) ? mask_a : mask_b;
    if (m_busy[i] == 0) begin
      if (st) begin
        m_busy[i] = 1; m_done[i] = 0; m_pass[i] = 0; m_err[i] = 0;
        m_fev[i] = 0; m_fei[i] = 0; m_t[i] = 0; m_vec[i] = 0;
      end
    end else begin
      m_t[i]++;
      if (m_t[i] % hold == 0) begin
        k = m_t[i] / hold - 1;
        if (dev_val(4'(k), mk) != dev_val(4'(k), 16'h0000)) begin
          if (m_err[i] < emax) m_err[i]++;
          if (m_fev[i] == 0) begin m_fev[i] = 1; m_fei[i] = k; end
        end
      end
      if (m_t[i] == 16 * hold) begin
        m_busy[i] = 0; m_done[i] = 1; m_pass[i] = (m_err[i] == 0) ? 1 : 0; m_vec[i] = 15;
      end else begin
        m_vec[i] = m_t[i] / hold;
      end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else for (int i = 0; i < 2; i++) model_step(i);
    end
  end

  // Every-cycle comparison against the model, away from the active edge
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        for (int i = 0; i < 2; i++)
          for (int j = 0; j < 7; j++)
            chk(out_name(i, j), out_val(i, j), model_val(i, j));
      end
    end
  end

  task automatic set_start(input int inst, input logic v);
    if (inst == 0) start_a = v; else start_b = v;
  endtask

  // One sweep; returns cycles from the start edge to done, or -1 if reset mid-way
  task automatic run(input int inst, input logic [15:0] mk, input int pulse_at,
                     input int rst_vec, output int cyc);
    @(negedge clk); #2;
    if (inst == 0) mask_a = mk; else mask_b = mk;
    set_start(inst, 1'b1);
    @(posedge clk); #1;
    set_start(inst, 1'b0);
    chk("start.busy", out_val(inst, 1), 1);
    chk("start.done", out_val(inst, 2), 0);
    chk("start.pass", out_val(inst, 3), 0);
    chk("start.vec_out", out_val(inst, 0), 0);
    chk("start.err_count", out_val(inst, 4), 0);
    cyc = 0;
    while (cyc < 4000) begin
      @(posedge clk); cyc++; #1;
      if (rst_vec >= 0 && out_val(inst, 0) == rst_vec) begin
        rst_n = 1'b0;
        #1;
        for (int j = 0; j < 7; j++) chk({"rst.", out_name(inst, j)}, out_val(inst, j), 0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        cyc = -1;
        return;
      end
      set_start(inst, cyc == pulse_at);
      if (out_val(inst, 2) == 1) break;
    end
    if (out_val(inst, 2) != 1) chk("done_timeout", out_val(inst, 2), 1);
  endtask

  initial begin
    int cyc;
    logic [15:0] rm;
    rst_n = 1'b1; start_a = 1'b0; start_b = 1'b0; mask_a = '0; mask_b = '0;
    #1 rst_n = 1'b0;
    #1;
    for (int j = 0; j < 7; j++) chk({"por.", out_name(0, j)}, out_val(0, j), 0);
    chk_en = 1'b1;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;

    // correct device
    run(0, 16'h0000, -1, -1, cyc);
    chk("good.latency", cyc, 320);
    chk("good.pass", int'(pass_a), 1);
    chk("good.err", int'(err_a), 0);
    chk("good.fev", int'(fev_a), 0);

    // inverted device, started from DONE with pass=1
    run(0, 16'hFFFF, -1, -1, cyc);
    chk("inv.err", int'(err_a), 16);
    chk("inv.fev", int'(fev_a), 1);
    chk("inv.fei", int'(fei_a), 0);
    chk("inv.pass", int'(pass_a), 0);

    // single fault at vector 9
    run(0, 16'h0200, -1, -1, cyc);
    chk("f9.err", int'(err_a), 1);
    chk("f9.fei", int'(fei_a), 9);
    chk("f9.pass", int'(pass_a), 0);

    // reset mid-sweep at vector 5, then a clean sweep
    run(0, 16'h0000, -1, 5, cyc);
    chk("rst.returned", cyc, -1);
    run(0, 16'h0000, -1, -1, cyc);
    chk("post_rst.err", int'(err_a), 0);
    chk("post_rst.pass", int'(pass_a), 1);

    // start pulse mid-sweep is ignored
    run(0, 16'h0000, 100, -1, cyc);
    chk("pulse.latency", cyc, 320);

    // random fault patterns
    for (int n = 0; n < 3; n++) begin
      rm = 16'($urandom);
      run(0, rm, -1, -1, cyc);
      chk("rand.latency", cyc, 320);
    end

    // HOLD=1, ERR_W=2
    run(1, 16'hFFFF, -1, -1, cyc);
    chk("b.latency", cyc, 16);
    chk("b.err", int'(err_b), 3);
    chk("b.fei", int'(fei_b), 0);
    chk("b.pass", int'(pass_b), 0);
    for (int n = 0; n < 4; n++) begin
      rm = 16'($urandom);
      run(1, rm, -1, -1, cyc);
      chk("b.rand.latency", cyc, 16);
    end

    // start held high re-triggers from DONE
    @(negedge clk); #2 start_b = 1'b1;
    repeat (60) @(posedge clk);
    #1 start_b = 1'b0;
    repeat (20) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
